// File: rtl/sfp_port_ctrl_pkg.sv
// Shared definitions for the SFP+ port controller: lane state encoding and sizing helpers.
package sfp_port_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ABSENT      = 3'd0,
        ST_DEBOUNCE    = 3'd1,
        ST_INIT        = 3'd2,
        ST_READY       = 3'd3,
        ST_FAULT_RST   = 3'd4,
        ST_FAULT_LATCH = 3'd5
    } sfp_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sfp_port_ctrl_lane_fsm.sv
// One SFP+ cage: pin synchronisers, insertion debounce, laser sequencing and
// bounded TX_FAULT recovery, with all status outputs registered.
module sfp_port_ctrl_lane_fsm
    import sfp_port_ctrl_pkg::*;
#(
    parameter int C_DEBOUNCE_CYC    = 156250,
    parameter int C_TINIT_CYC       = 46875000,
    parameter int C_TXDIS_PULSE_CYC = 1563,
    parameter int C_RETRY_MAX       = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mod_abs_i,
    input  logic               tx_fault_i,
    input  logic               rx_los_i,
    input  logic               force_disable_i,
    input  logic               fault_clear_i,
    input  logic               rate_sel_i,
    output logic               tx_disable_o,
    output logic               rs_o,
    output logic               port_ready_o,
    output logic               link_up_o,
    output logic               fault_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W   = $clog2(max3(C_DEBOUNCE_CYC, C_TINIT_CYC, C_TXDIS_PULSE_CYC)) + 1;
    localparam int RETRY_W = $clog2(C_RETRY_MAX + 1) + 1;

    localparam logic [CNT_W-1:0]   DEB_LAST   = CNT_W'(C_DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]   TINIT_LAST = CNT_W'(C_TINIT_CYC - 1);
    localparam logic [CNT_W-1:0]   PULSE_LAST = CNT_W'(C_TXDIS_PULSE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(C_RETRY_MAX);

    logic [1:0]         abs_sync_q, flt_sync_q, los_sync_q;
    logic               mod_abs_s, tx_fault_s, rx_los_s;
    sfp_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               timed_s;
    logic               tx_disable_q, rs_q, port_ready_q, link_up_q, fault_q;

    assign mod_abs_s  = abs_sync_q[1];
    assign tx_fault_s = flt_sync_q[1];
    assign rx_los_s   = los_sync_q[1];
    assign timed_s    = (state_q == ST_DEBOUNCE) || (state_q == ST_INIT) || (state_q == ST_FAULT_RST);

    // Next-state, dwell counter and retry bookkeeping; removal/force-off override everything.
    always_comb begin
        state_d = state_q;
        if (mod_abs_s || force_disable_i) begin
            state_d = ST_ABSENT;
        end else if ((state_q == ST_FAULT_LATCH) && fault_clear_i) begin
            state_d = ST_ABSENT;
        end else begin
            case (state_q)
                ST_ABSENT:      state_d = ST_DEBOUNCE;
                ST_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) state_d = ST_INIT;
                    else                   state_d = ST_DEBOUNCE;
                end
                ST_INIT: begin
                    if (cnt_q == TINIT_LAST) state_d = tx_fault_s ? ST_FAULT_RST : ST_READY;
                    else                     state_d = ST_INIT;
                end
                ST_READY: begin
                    if (tx_fault_s) state_d = ST_FAULT_RST;
                    else            state_d = ST_READY;
                end
                ST_FAULT_RST: begin
                    if (cnt_q == PULSE_LAST) state_d = (retry_q > RETRY_LIM) ? ST_FAULT_LATCH : ST_INIT;
                    else                     state_d = ST_FAULT_RST;
                end
                ST_FAULT_LATCH: state_d = ST_FAULT_LATCH;
                default:        state_d = ST_ABSENT;
            endcase
        end

        if ((state_d == state_q) && timed_s) cnt_d = cnt_q + CNT_W'(1);
        else                                 cnt_d = '0;

        if (state_q == ST_ABSENT) begin
            retry_d = '0;
        end else if ((state_d == ST_FAULT_RST) && (state_q != ST_FAULT_RST) && (retry_q != '1)) begin
            retry_d = retry_q + RETRY_W'(1);
        end else begin
            retry_d = retry_q;
        end
    end

    // State, synchronisers and outputs; outputs are decoded from the next state so they track State.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            abs_sync_q   <= 2'b11;
            flt_sync_q   <= 2'b00;
            los_sync_q   <= 2'b11;
            state_q      <= ST_ABSENT;
            cnt_q        <= '0;
            retry_q      <= '0;
            tx_disable_q <= 1'b1;
            rs_q         <= 1'b1;
            port_ready_q <= 1'b0;
            link_up_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            abs_sync_q   <= {abs_sync_q[0], mod_abs_i};
            flt_sync_q   <= {flt_sync_q[0], tx_fault_i};
            los_sync_q   <= {los_sync_q[0], rx_los_i};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            tx_disable_q <= !((state_d == ST_INIT) || (state_d == ST_READY));
            rs_q         <= rate_sel_i;
            port_ready_q <= (state_d == ST_READY);
            link_up_q    <= (state_d == ST_READY) && !rx_los_s;
            fault_q      <= (state_d == ST_FAULT_LATCH);
        end
    end

    assign tx_disable_o = tx_disable_q;
    assign rs_o         = rs_q;
    assign port_ready_o = port_ready_q;
    assign link_up_o    = link_up_q;
    assign fault_o      = fault_q;
    assign state_o      = state_q;

endmodule

// File: rtl/sfp_port_ctrl.sv
// Multi-cage SFP+ management: one independent lane controller per port, buses packed per port.
module sfp_port_ctrl
    import sfp_port_ctrl_pkg::*;
#(
    parameter int C_NUM_PORTS       = 4,
    parameter int C_DEBOUNCE_CYC    = 156250,
    parameter int C_TINIT_CYC       = 46875000,
    parameter int C_TXDIS_PULSE_CYC = 1563,
    parameter int C_RETRY_MAX       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [C_NUM_PORTS-1:0]         MOD_ABS,
    input  logic [C_NUM_PORTS-1:0]         TX_FAULT,
    input  logic [C_NUM_PORTS-1:0]         RX_LOS,
    input  logic [C_NUM_PORTS-1:0]         Force_disable,
    input  logic [C_NUM_PORTS-1:0]         Fault_clear,
    input  logic [C_NUM_PORTS-1:0]         Rate_sel,
    output logic [C_NUM_PORTS-1:0]         TX_DISABLE,
    output logic [C_NUM_PORTS-1:0]         RS,
    output logic [C_NUM_PORTS-1:0]         Port_ready,
    output logic [C_NUM_PORTS-1:0]         Link_up,
    output logic [C_NUM_PORTS-1:0]         Fault,
    output logic [STATE_W*C_NUM_PORTS-1:0] State
);

    for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_lane
        sfp_port_ctrl_lane_fsm #(
            .C_DEBOUNCE_CYC    (C_DEBOUNCE_CYC),
            .C_TINIT_CYC       (C_TINIT_CYC),
            .C_TXDIS_PULSE_CYC (C_TXDIS_PULSE_CYC),
            .C_RETRY_MAX       (C_RETRY_MAX)
        ) u_lane (
            .clk_i           (clk),
            .rst_i           (rst),
            .mod_abs_i       (MOD_ABS[i]),
            .tx_fault_i      (TX_FAULT[i]),
            .rx_los_i        (RX_LOS[i]),
            .force_disable_i (Force_disable[i]),
            .fault_clear_i   (Fault_clear[i]),
            .rate_sel_i      (Rate_sel[i]),
            .tx_disable_o    (TX_DISABLE[i]),
            .rs_o            (RS[i]),
            .port_ready_o    (Port_ready[i]),
            .link_up_o       (Link_up[i]),
            .fault_o         (Fault[i]),
            .state_o         (State[STATE_W*i +: STATE_W])
        );
    end

endmodule

// File: tb/tb_sfp_port_ctrl.sv
// Scoreboard bench for sfp_port_ctrl: a countdown-based reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_sfp_port_ctrl;

    localparam int N     = 4;
    localparam int DEB   = 8;
    localparam int TINIT = 16;
    localparam int PULSE = 4;
    localparam int RMAX  = 2;

    localparam int S_ABSENT = 0, S_DEB = 1, S_INIT = 2, S_READY = 3, S_FRST = 4, S_LATCH = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   MOD_ABS, TX_FAULT, RX_LOS, Force_disable, Fault_clear, Rate_sel;
    logic [N-1:0]   TX_DISABLE, RS, Port_ready, Link_up, Fault;
    logic [3*N-1:0] State;

    always #5 clk = ~clk;

    sfp_port_ctrl #(
        .C_NUM_PORTS       (N),
        .C_DEBOUNCE_CYC    (DEB),
        .C_TINIT_CYC       (TINIT),
        .C_TXDIS_PULSE_CYC (PULSE),
        .C_RETRY_MAX       (RMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .MOD_ABS       (MOD_ABS),
        .TX_FAULT      (TX_FAULT),
        .RX_LOS        (RX_LOS),
        .Force_disable (Force_disable),
        .Fault_clear   (Fault_clear),
        .Rate_sel      (Rate_sel),
        .TX_DISABLE    (TX_DISABLE),
        .RS            (RS),
        .Port_ready    (Port_ready),
        .Link_up       (Link_up),
        .Fault         (Fault),
        .State         (State)
    );

    typedef struct packed {
        logic [N-1:0]   txd;
        logic [N-1:0]   rs;
        logic [N-1:0]   rdy;
        logic [N-1:0]   link;
        logic [N-1:0]   flt;
        logic [3*N-1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: pin delay lines, state, remaining dwell cycles, retries.
    bit m_a1[N], m_a2[N], m_f1[N], m_f2[N], m_l1[N], m_l2[N];
    int m_state[N], m_rem[N], m_retry[N];

    function automatic int dwell(input int s);
        case (s)
            S_DEB:   return DEB;
            S_INIT:  return TINIT;
            S_FRST:  return PULSE;
            default: return 0;
        endcase
    endfunction

    task automatic model_cycle();
        exp_t e;
        bit   sa, sf, sl;
        int   cur, nxt;
        e = '0;
        for (int p = 0; p < N; p++) begin
            if (rst) begin
                m_a1[p] = 1'b1; m_a2[p] = 1'b1;
                m_f1[p] = 1'b0; m_f2[p] = 1'b0;
                m_l1[p] = 1'b1; m_l2[p] = 1'b1;
                m_state[p] = S_ABSENT; m_rem[p] = 0; m_retry[p] = 0;
                e.txd[p] = 1'b1;
                e.rs[p]  = 1'b1;
            end else begin
                sa = m_a2[p]; sf = m_f2[p]; sl = m_l2[p];
                m_a2[p] = m_a1[p]; m_a1[p] = MOD_ABS[p];
                m_f2[p] = m_f1[p]; m_f1[p] = TX_FAULT[p];
                m_l2[p] = m_l1[p]; m_l1[p] = RX_LOS[p];
                cur = m_state[p];
                nxt = cur;
                if (sa || Force_disable[p])              nxt = S_ABSENT;
                else if (cur == S_LATCH && Fault_clear[p]) nxt = S_ABSENT;
                else if (cur == S_ABSENT)                nxt = S_DEB;
                else if (cur == S_DEB && m_rem[p] == 1)  nxt = S_INIT;
                else if (cur == S_INIT && m_rem[p] == 1) nxt = sf ? S_FRST : S_READY;
                else if (cur == S_READY && sf)           nxt = S_FRST;
                else if (cur == S_FRST && m_rem[p] == 1) nxt = (m_retry[p] > RMAX) ? S_LATCH : S_INIT;
                if (cur == S_ABSENT) m_retry[p] = 0;
                if (nxt == S_FRST && cur != S_FRST) m_retry[p] = m_retry[p] + 1;
                if (nxt != cur) m_rem[p] = dwell(nxt);
                else            m_rem[p] = m_rem[p] - 1;
                m_state[p] = nxt;
                e.txd[p]  = !(nxt == S_INIT || nxt == S_READY);
                e.rs[p]   = Rate_sel[p];
                e.rdy[p]  = (nxt == S_READY);
                e.link[p] = (nxt == S_READY) && !sl;
                e.flt[p]  = (nxt == S_LATCH);
                e.st[3*p +: 3] = 3'(nxt);
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, req);
        end
    endtask

    // Monitor: every output update is compared against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("TX_DISABLE", 12'(TX_DISABLE), 12'(e.txd));
                chk("RS",         12'(RS),         12'(e.rs));
                chk("Port_ready", 12'(Port_ready), 12'(e.rdy));
                chk("Link_up",    12'(Link_up),    12'(e.link));
                chk("Fault",      12'(Fault),      12'(e.flt));
                chk("State",      State,           e.st);
            end
        end
    end

    initial begin
        rst = 1'b1; MOD_ABS = 4'hF; TX_FAULT = 4'h0; RX_LOS = 4'h0;
        Force_disable = 4'h0; Fault_clear = 4'h0; Rate_sel = 4'h0;
        run(3);
        rst = 1'b0;
        Rate_sel = 4'h5;
        run(6);

        // Port 0 insertion to READY.
        MOD_ABS[0] = 1'b0;
        run(40);

        // Port 3 removal glitch never reaches INIT.
        MOD_ABS[3] = 1'b0;
        run(5);
        MOD_ABS[3] = 1'b1;
        run(10);

        // Port 1: link loss then forced off.
        MOD_ABS[1] = 1'b0;
        run(35);
        RX_LOS[1] = 1'b1;
        run(4);
        Force_disable[1] = 1'b1;
        run(4);
        Force_disable[1] = 1'b0;
        RX_LOS[1] = 1'b0;
        run(35);

        // Port 0 persistent fault: retries, latch, clear, restart.
        TX_FAULT[0] = 1'b1;
        run(110);
        Fault_clear[0] = 1'b1;
        run(1);
        Fault_clear[0] = 1'b0;
        TX_FAULT[0] = 1'b0;
        run(40);

        // Reset in the middle of port 2 initialisation.
        MOD_ABS[2] = 1'b0;
        run(16);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(40);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(79, 0) == 0) MOD_ABS[p] = ~MOD_ABS[p];
                if ($urandom_range(49, 0) == 0) TX_FAULT[p] = ~TX_FAULT[p];
                if ($urandom_range(15, 0) == 0) RX_LOS[p] = ~RX_LOS[p];
                if ($urandom_range(149, 0) == 0) Force_disable[p] = ~Force_disable[p];
                Fault_clear[p] = ($urandom_range(19, 0) == 0);
                Rate_sel[p] = 1'($urandom_range(1, 0));
            end
            rst = ($urandom_range(699, 0) == 0);
            step();
        end
        rst = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
